// File: rtl/uart_tx_bh.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to include the even-parity bit between the last data bit and the stop bit.
module uart_tx_bh #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic              baud_last;
    logic              next_bit;

    // Bit that will sit at position 0 after the next shift; a 1-bit word has none.
    generate
        if (DATA_W > 1) begin : g_next_wide
            assign next_bit = shift_q[1];
        end else begin : g_next_narrow
            assign next_bit = 1'b0;
        end
    endgenerate

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    bit_d    = '0;
                    state_d  = S_START;
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = next_bit;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txd      = txd_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;

endmodule

// File: doc/uart_tx_bh.md
# uart_tx_bh

Asynchronous-serial transmitter that accepts a parallel word over a valid/ready handshake and drives it onto a single line. The frame is a start bit, data LSB first, an optional even-parity bit and one stop bit. It is the transmit-side companion to the team's registered storage and receive-side primitives, and sits between a parallel producer and an off-chip serial line.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; must be at least 1.
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, reset is asynchronous and active-low (rst=0 resets immediately, independent of clk).
- tx_data  input  DATA_W  word to send; sampled only on the accept edge.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  transmitter can accept a word; high only in IDLE.
- txd  output  1  serial line; idles high; registered.
- busy  output  1  frame in progress; high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY (present only if compiled in), STOP.
- Reset values while rst=0: state=IDLE, txd=1, tx_ready=1, busy=0, bit counter=0, baud counter=0, shift register=0.
- IDLE:
  - txd=1.
  - Accept when tx_valid=1 and tx_ready=1 on a rising edge: tx_data is captured into the shift register, and the block goes to START.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - txd = shift register bit 0.
  - Every CLKS_PER_BIT cycles, shift right and increment the bit counter.
  - After DATA_W bits, go to PARITY if enabled, otherwise STOP.
- PARITY: txd = XOR of all captured data bits (even parity), for CLKS_PER_BIT cycles, then STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - Its width is $clog2(CLKS_PER_BIT), minimum 1.
  - The bit counter width is $clog2(DATA_W+1).
- Changes on tx_data or tx_valid outside the accept edge have no effect.
- tx_valid is ignored while busy; the word is neither queued nor dropped silently as accepted.

## Timing
- Let A be the accept edge.
- Start bit: txd=0 from edge A to edge A+CLKS_PER_BIT.
- Data bit i (0-based) occupies edges A+(1+i)·C through A+(2+i)·C, where C=CLKS_PER_BIT.
- Frame length F = (2+DATA_W+P)·C cycles, with P=1 if parity is enabled, else 0.
- End of frame: at edge A+F the state returns to IDLE, and tx_ready=1 and busy=0 in the cycle that follows.
- Earliest next accept is edge A+F+1, so back-to-back frame period is F+1 cycles.
- tx_ready and busy are registered, changing only on the edges above or on reset.
- Reset mid-frame: txd=1 and tx_ready=1 immediately on rst falling; the frame is abandoned with no partial completion.
- Reset release: the first accept is possible on the first rising edge with rst=1.
- C=1 is legal: each bit lasts exactly one cycle.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state exists, P=1.
  - The even-parity bit is sent between the last data bit and the stop bit.
- Undefined:
  - The PARITY state and parity logic are absent, P=0.
  - STOP follows the last data bit directly.

## Test plan
- Reset: hold rst=0 with tx_valid=1 -> txd=1, tx_ready=1, busy=0, and no frame starts. Assert rst=0 mid-DATA -> txd=1 within the same cycle.
- Single frame (DATA_W=8, C=4, no parity): send 8'hA5 -> txd sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. busy is high for exactly 40 cycles.
- Parity enabled: send 8'h07 -> parity bit=1 in bit slot 9. Send 8'h03 -> parity bit=0. Frame is 44 cycles.
- Back-to-back: hold tx_valid=1 with 8'h55 then 8'h0F -> second accept exactly 41 cycles after the first. tx_ready is low for cycles 1-40.
- Ignore-while-busy: pulse tx_valid with 8'hFF mid-frame -> no effect on txd, and no second frame.
- Boundary C=1, DATA_W=1: send 1'b1 -> txd=0,1,1 over three cycles, then idle high.
